// File: rtl/mux_n_1_scan.sv
// mux_n_1_scan
//   Registered N:1 channel multiplexer with manual select and auto-scan.
//   In manual mode the channel chosen by sel is registered to out. In scan
//   mode an internal pointer steps through every channel. Each channel is
//   held for dwell+1 enabled cycles, and ch_wrap pulses on the last sample
//   of the final channel. When en is low the outputs hold, the valid and
//   wrap flags drop, and the scan state freezes.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   din       in   packed channel data, channel k at [k*WIDTH +: WIDTH]
//   sel       in   manual channel select
//   mode      in   0 = manual, 1 = auto scan
//   en        in   enable; low pauses the block
//   dwell     in   extra enabled cycles each channel is held while scanning
//   out       out  registered selected data
//   out_ch    out  channel index of out
//   out_valid out  out/out_ch hold a valid sample
//   ch_wrap   out  pulse on the final sample of channel NUM_CH-1 while scanning

module mux_n_1_scan #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*WIDTH-1:0]  din,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    input  logic                     en,
    input  logic [DWELL_W-1:0]       dwell,
    output logic [WIDTH-1:0]         out,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    output logic                     ch_wrap
);

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);

    // Operating mode for the current cycle, decoded from en/mode.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_MANUAL,
        OP_SCAN
    } op_t;

    op_t op;

    logic [WIDTH-1:0]   chan [NUM_CH];
    logic [SEL_W-1:0]   ptr, ptr_d, p_eff;
    logic [DWELL_W-1:0] cnt, cnt_d, c_eff;
    logic               mode_q, mode_q_d;
    logic [WIDTH-1:0]   out_d;
    logic [SEL_W-1:0]   out_ch_d;
    logic               valid_d, wrap_d;
    logic               sel_ok;

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            chan[k] = din[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        op = OP_IDLE;
        if (en) begin
            op = mode ? OP_SCAN : OP_MANUAL;
        end
    end

    assign sel_ok = ({1'b0, sel} < NUM_CH_X);

    // A fresh scan entry behaves as if ptr and cnt were zero. The stored
    // values may be stale from an earlier, abandoned scan.
    assign p_eff = mode_q ? ptr : '0;
    assign c_eff = mode_q ? cnt : '0;

    always_comb begin
        out_d    = out;
        out_ch_d = out_ch;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;
        ptr_d    = ptr;
        cnt_d    = cnt;
        mode_q_d = mode_q;

        case (op)
            OP_MANUAL: begin
                mode_q_d = 1'b0;
                out_ch_d = sel;
                if (sel_ok) begin
                    out_d   = chan[sel];
                    valid_d = 1'b1;
                end else begin
                    out_d   = '0;
                end
            end
            OP_SCAN: begin
                mode_q_d = 1'b1;
                out_d    = chan[p_eff];
                out_ch_d = p_eff;
                valid_d  = 1'b1;
                ptr_d    = p_eff;
                // Using >= lets a lowered dwell take effect mid-hold.
                if (c_eff >= dwell) begin
                    cnt_d  = '0;
                    wrap_d = (p_eff == LAST_CH);
                    ptr_d  = (p_eff == LAST_CH) ? '0 : p_eff + SEL_W'(1);
                end else begin
                    cnt_d  = c_eff + DWELL_W'(1);
                end
            end
            default: begin
                // Paused: outputs hold, flags drop, scan state frozen.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ch_wrap   <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
        end else begin
            out       <= out_d;
            out_ch    <= out_ch_d;
            out_valid <= valid_d;
            ch_wrap   <= wrap_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            mode_q    <= mode_q_d;
        end
    end

endmodule

// File: tb/tb_mux_n_1_scan.sv
// tb_mux_n_1_scan
//   Drives a 4-channel and a 3-channel instance from shared stimulus and
//   checks both every cycle against a behavioural channel-scanner model.
//   Directed scenarios are followed by randomized traffic.

module tb_mux_n_1_scan;

    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [1:0]  sel;
    logic [7:0]  dwell;
    logic [31:0] din;
    logic [23:0] din3;

    logic [7:0]  out4, out3;
    logic [1:0]  ch4, ch3;
    logic        v4, v3, w4, w3;

    int compared   = 0;
    int mismatched = 0;

    // Model state, index 0 = 4-channel instance, index 1 = 3-channel instance.
    int nch     [2] = '{4, 3};
    int m_out   [2] = '{0, 0};
    int m_ch    [2] = '{0, 0};
    int m_valid [2] = '{0, 0};
    int m_wrap  [2] = '{0, 0};
    int m_ptr   [2] = '{0, 0};
    int m_cnt   [2] = '{0, 0};
    int m_scan  [2] = '{0, 0};

    always #5 clk = ~clk;

    assign din3 = din[23:0];

    mux_n_1_scan #(.WIDTH(8), .NUM_CH(4), .SEL_W(2), .DWELL_W(8)) dut4 (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
        .dwell(dwell), .out(out4), .out_ch(ch4), .out_valid(v4), .ch_wrap(w4)
    );

    mux_n_1_scan #(.WIDTH(8), .NUM_CH(3), .SEL_W(2), .DWELL_W(8)) dut3 (
        .clk(clk), .rst(rst), .din(din3), .sel(sel), .mode(mode), .en(en),
        .dwell(dwell), .out(out3), .out_ch(ch3), .out_valid(v3), .ch_wrap(w3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input int i);
        int n = nch[i];
        int s = int'(sel);
        int d = int'(dwell);
        if (rst) begin
            m_out[i] = 0; m_ch[i] = 0; m_valid[i] = 0; m_wrap[i] = 0;
            m_ptr[i] = 0; m_cnt[i] = 0; m_scan[i] = 0;
        end else if (!en) begin
            m_valid[i] = 0;
            m_wrap[i]  = 0;
        end else if (!mode) begin
            m_scan[i] = 0;
            m_wrap[i] = 0;
            m_ch[i]   = s;
            if (s < n) begin
                m_out[i]   = int'((din >> (8 * s)) & 32'hFF);
                m_valid[i] = 1;
            end else begin
                m_out[i]   = 0;
                m_valid[i] = 0;
            end
        end else begin
            if (m_scan[i] == 0) begin
                m_ptr[i]  = 0;
                m_cnt[i]  = 0;
                m_scan[i] = 1;
            end
            m_out[i]   = int'((din >> (8 * m_ptr[i])) & 32'hFF);
            m_ch[i]    = m_ptr[i];
            m_valid[i] = 1;
            if (m_cnt[i] >= d) begin
                m_cnt[i]  = 0;
                m_wrap[i] = (m_ptr[i] == n - 1) ? 1 : 0;
                m_ptr[i]  = (m_ptr[i] + 1) % n;
            end else begin
                m_cnt[i]  = m_cnt[i] + 1;
                m_wrap[i] = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic m,
                        input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        rst = r; en = e; mode = m; sel = s; dwell = d;
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check("m4_out",   32'(out4), m_out[0]);
        check("m4_ch",    32'(ch4),  m_ch[0]);
        check("m4_valid", 32'(v4),   m_valid[0]);
        check("m4_wrap",  32'(w4),   m_wrap[0]);
        check("m3_out",   32'(out3), m_out[1]);
        check("m3_ch",    32'(ch3),  m_ch[1]);
        check("m3_valid", 32'(v3),   m_valid[1]);
        check("m3_wrap",  32'(w3),   m_wrap[1]);
    endtask

    task automatic expect4(input string tag, input logic [7:0] o, input logic [1:0] c,
                           input logic v, input logic w);
        check({tag, "_out"},   32'(out4), 32'(o));
        check({tag, "_ch"},    32'(ch4),  32'(c));
        check({tag, "_valid"}, 32'(v4),   32'(v));
        check({tag, "_wrap"},  32'(w4),   32'(w));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; dwell = '0;
        din = 32'h44332211;

        // Reset, then manual sweep
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        expect4("reset", 8'h00, 2'd0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            step(0, 1, 0, 2'(s), 0);
            expect4("manual", 8'(8'h11 * (s + 1)), 2'(s), 1, 0);
        end

        // Scan with dwell=0
        for (int k = 0; k < 9; k++) begin
            step(0, 1, 1, 0, 0);
            expect4("scan_d0", 8'(8'h11 * (k % 4 + 1)), 2'(k % 4), 1, (k % 4) == 3);
        end

        // Scan with dwell=2, pause, reset
        step(0, 1, 0, 0, 2);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 1, 0, 2);
            expect4("scan_d2", 8'(8'h11 * (k / 3 + 1)), 2'(k / 3), 1, k == 11);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 0, 2);
            expect4("scan_d2b", (k < 3) ? 8'h11 : 8'h22, (k < 3) ? 2'd0 : 2'd1, 1, 0);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 2);
            expect4("paused", 8'h22, 2'd1, 0, 0);
        end
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 1, 0, 2);
            expect4("resumed", 8'h22, 2'd1, 1, 0);
        end
        step(0, 1, 1, 0, 2);
        expect4("ch2", 8'h33, 2'd2, 1, 0);
        step(1, 1, 1, 0, 2);
        expect4("mid_rst", 8'h00, 2'd0, 0, 0);
        step(0, 1, 1, 0, 2);
        expect4("rescan", 8'h11, 2'd0, 1, 0);

        // Dwell lowered mid-hold
        step(0, 1, 0, 0, 5);
        step(0, 1, 1, 0, 5);
        expect4("dw5_a", 8'h11, 2'd0, 1, 0);
        step(0, 1, 1, 0, 5);
        expect4("dw5_b", 8'h11, 2'd0, 1, 0);
        step(0, 1, 1, 0, 1);
        expect4("dw1_adv", 8'h11, 2'd0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 0, 1);
            expect4("dw1", 8'(8'h11 * (k / 2 + 2)), 2'(k / 2 + 1), 1, 0);
        end

        // Mode switching
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 0, 0);
            expect4("ms_scan", 8'(8'h11 * (k + 1)), 2'(k), 1, 0);
        end
        step(0, 1, 0, 1, 0);
        expect4("ms_man", 8'h22, 2'd1, 1, 0);
        step(0, 1, 1, 0, 0);
        expect4("ms_rescan", 8'h11, 2'd0, 1, 0);

        // Out-of-range select on the 3-channel build
        step(0, 1, 0, 3, 0);
        check("oor_out",   32'(out3), 32'h0);
        check("oor_ch",    32'(ch3),  32'd3);
        check("oor_valid", 32'(v3),   32'd0);
        expect4("inrange3", 8'h44, 2'd3, 1, 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            din = $urandom;
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
